// File: rtl/junction_pkg.sv
// Shared types and defaults for the junction lamp controller.
package junction_pkg;

  typedef enum logic [3:0] {
    ALLRED_A,
    NS_RA,
    NS_G,
    NS_A,
    ALLRED_B,
    EW_RA,
    EW_G,
    EW_A,
    WALK
  } state_t;

  localparam int DEF_GREEN_CYC = 8;
  localparam int DEF_AMBER_CYC = 2;
  localparam int DEF_CLEAR_CYC = 1;
  localparam int DEF_WALK_CYC  = 4;

  typedef struct packed {
    logic ns_red;
    logic ns_amber;
    logic ns_green;
    logic ew_red;
    logic ew_amber;
    logic ew_green;
    logic walk;
  } lamps_t;

  // A dwell of 0 cycles is treated as 1 so the sequence can never stall.
  function automatic int eff_cyc(input int p);
    return (p < 1) ? 1 : p;
  endfunction

  function automatic lamps_t lamp_decode(input state_t s);
    lamps_t l;
    l = '{ns_red: 1'b1, ns_amber: 1'b0, ns_green: 1'b0,
          ew_red: 1'b1, ew_amber: 1'b0, ew_green: 1'b0, walk: 1'b0};
    case (s)
      NS_RA: l.ns_amber = 1'b1;
      NS_G: begin
        l.ns_red   = 1'b0;
        l.ns_green = 1'b1;
      end
      NS_A: begin
        l.ns_red   = 1'b0;
        l.ns_amber = 1'b1;
      end
      EW_RA: l.ew_amber = 1'b1;
      EW_G: begin
        l.ew_red   = 1'b0;
        l.ew_green = 1'b1;
      end
      EW_A: begin
        l.ew_red   = 1'b0;
        l.ew_amber = 1'b1;
      end
      WALK: l.walk = 1'b1;
      default: ;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/junction_if.sv
// Pedestrian request/ack and lamp drives of one junction.
interface junction_if;
  logic ped_req;
  logic ped_ack;
  logic ns_red;
  logic ns_amber;
  logic ns_green;
  logic ew_red;
  logic ew_amber;
  logic ew_green;
  logic walk;

  modport master (
    input  ped_req,
    output ped_ack, ns_red, ns_amber, ns_green, ew_red, ew_amber, ew_green, walk
  );

  modport slave (
    output ped_req,
    input  ped_ack, ns_red, ns_amber, ns_green, ew_red, ew_amber, ew_green, walk
  );
endinterface

// File: rtl/junction_dwell_timer.sv
// Phase dwell down-counter: load duration-1, done while it reads zero.
module dwell_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt;

  // Reload on every phase entry, otherwise count down and hold at zero.
  always_ff @(posedge clk) begin
    if (load) cnt <= load_val;
    else if (cnt != '0) cnt <= cnt - 1'b1;
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/junction_ctrl.sv
// Two-road junction lamp sequencer with pedestrian walk insertion.
module junction_ctrl
  import junction_pkg::*;
#(
  parameter int GREEN_CYC = DEF_GREEN_CYC,
  parameter int AMBER_CYC = DEF_AMBER_CYC,
  parameter int CLEAR_CYC = DEF_CLEAR_CYC,
  parameter int WALK_CYC  = DEF_WALK_CYC
) (
  input  logic       clk,
  input  logic       rst_n,
  junction_if.master jif
);

  localparam int G_EFF  = eff_cyc(GREEN_CYC);
  localparam int A_EFF  = eff_cyc(AMBER_CYC);
  localparam int C_EFF  = eff_cyc(CLEAR_CYC);
  localparam int W_EFF  = eff_cyc(WALK_CYC);
  localparam int MAX_GA = (G_EFF > A_EFF) ? G_EFF : A_EFF;
  localparam int MAX_CW = (C_EFF > W_EFF) ? C_EFF : W_EFF;
  localparam int MAX_D  = (MAX_GA > MAX_CW) ? MAX_GA : MAX_CW;
  localparam int CW     = $clog2(MAX_D) + 1;

  localparam logic [CW-1:0] GREEN_M1 = CW'(G_EFF - 1);
  localparam logic [CW-1:0] AMBER_M1 = CW'(A_EFF - 1);
  localparam logic [CW-1:0] CLEAR_M1 = CW'(C_EFF - 1);
  localparam logic [CW-1:0] WALK_M1  = CW'(W_EFF - 1);

  state_t        state, state_nxt;
  logic          pend, pend_nxt;
  logic          ret_ns, ret_nxt;
  logic          enter_walk;
  logic          load, done;
  logic [CW-1:0] dur_m1, load_val;
  lamps_t        lamps_q;
  logic          ack_q;

  dwell_timer #(.W(CW)) u_timer (
    .clk      (clk),
    .load     (load),
    .load_val (load_val),
    .done     (done)
  );

  // Next phase, pedestrian bookkeeping and the dwell to load on entry.
  always_comb begin
    state_nxt = state;
    pend_nxt  = pend;
    ret_nxt   = ret_ns;
    if (done) begin
      case (state)
        ALLRED_A: state_nxt = (pend || jif.ped_req) ? WALK : NS_RA;
        NS_RA:    state_nxt = NS_G;
        NS_G:     state_nxt = NS_A;
        NS_A:     state_nxt = ALLRED_B;
        ALLRED_B: state_nxt = (pend || jif.ped_req) ? WALK : EW_RA;
        EW_RA:    state_nxt = EW_G;
        EW_G:     state_nxt = EW_A;
        EW_A:     state_nxt = ALLRED_A;
        WALK:     state_nxt = ret_ns ? NS_RA : EW_RA;
        default:  state_nxt = ALLRED_A;
      endcase
    end
    enter_walk = (state_nxt == WALK) && (state != WALK);
    if (enter_walk) begin
      pend_nxt = 1'b0;
      ret_nxt  = (state == ALLRED_A);
    end else if (jif.ped_req && (state != WALK)) begin
      pend_nxt = 1'b1;
    end
    case (state_nxt)
      NS_G, EW_G:                 dur_m1 = GREEN_M1;
      NS_RA, NS_A, EW_RA, EW_A:   dur_m1 = AMBER_M1;
      WALK:                       dur_m1 = WALK_M1;
      default:                    dur_m1 = CLEAR_M1;
    endcase
    load     = !rst_n || done;
    load_val = rst_n ? dur_m1 : CLEAR_M1;
  end

  // State, flags and lamp registers; lamps follow the next state so they switch on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ALLRED_A;
      pend    <= 1'b0;
      ret_ns  <= 1'b0;
      lamps_q <= lamp_decode(ALLRED_A);
      ack_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      pend    <= pend_nxt;
      ret_ns  <= ret_nxt;
      lamps_q <= lamp_decode(state_nxt);
      ack_q   <= enter_walk;
    end
  end

  assign jif.ns_red   = lamps_q.ns_red;
  assign jif.ns_amber = lamps_q.ns_amber;
  assign jif.ns_green = lamps_q.ns_green;
  assign jif.ew_red   = lamps_q.ew_red;
  assign jif.ew_amber = lamps_q.ew_amber;
  assign jif.ew_green = lamps_q.ew_green;
  assign jif.walk     = lamps_q.walk;
  assign jif.ped_ack  = ack_q;

endmodule
